// File: rtl/md4_compress_iter.sv
// md4_compress_iter: iterative MD4 compression core.
//   Runs all 48 MD4 steps (ROUNDS=3) or the 16 round-1 steps (ROUNDS=1)
//   at UNROLL steps per clock. It keeps the chaining value between blocks
//   and applies the feed-forward addition in full MD4 mode.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   block handshake; in_ready is high only in IDLE
//   in_first            1: seed from the IV, 0: seed from the stored chain
//   block_in            512-bit block, word j = block_in[32j+31:32j]
//   out_valid/out_ready digest handshake; digest_out holds while out_valid is high
//   digest_out          {A,B,C,D}, with A in [127:96]
//   busy                high in RUN or DONE
module md4_compress_iter #(
    parameter int UNROLL = 1,
    parameter int ROUNDS = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [511:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] digest_out,
    output logic         busy
);
    localparam int TOTAL = (ROUNDS == 3) ? 48 : 16;
    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    generate
        if (!((ROUNDS == 1 || ROUNDS == 3) &&
              (UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 || UNROLL == 16) &&
              (TOTAL % UNROLL == 0))) begin : g_cfg_err
            $error("md4_compress_iter: illegal ROUNDS/UNROLL combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [5:0]    cnt;
    logic [127:0]  work, seed, chain, work_next, result;
    logic [511:0]  blk;
    logic [5:0]    cnt_next;

    // Message word index: round 2 transposes the 4x4 index grid,
    // round 3 bit-reverses the in-round step number.
    function automatic logic [3:0] msg_idx(input logic [5:0] i);
        case (i[5:4])
            2'd0:    return i[3:0];
            2'd1:    return {i[1:0], i[3:2]};
            default: return {i[0], i[1], i[2], i[3]};
        endcase
    endfunction

    function automatic logic [4:0] shamt(input logic [5:0] i);
        case ({i[5:4], i[1:0]})
            4'b0000: return 5'd3;
            4'b0001: return 5'd7;
            4'b0010: return 5'd11;
            4'b0011: return 5'd19;
            4'b0100: return 5'd3;
            4'b0101: return 5'd5;
            4'b0110: return 5'd9;
            4'b0111: return 5'd13;
            4'b1000: return 5'd3;
            4'b1001: return 5'd9;
            4'b1010: return 5'd11;
            default: return 5'd15;
        endcase
    endfunction

    function automatic logic [31:0] round_f(input logic [1:0] r, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] z);
        case (r)
            2'd0:    return (x & y) | (~x & z);
            2'd1:    return (x & y) | (x & z) | (y & z);
            default: return x ^ y ^ z;
        endcase
    endfunction

    function automatic logic [31:0] round_k(input logic [1:0] r);
        case (r)
            2'd0:    return 32'h0;
            2'd1:    return 32'h5a827999;
            default: return 32'h6ed9eba1;
        endcase
    endfunction

    // Rotate via a doubled word so shift amounts never need a 32-s term.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    // UNROLL chained steps starting at step cnt. The register roles rotate
    // each step, so after any multiple of 4 steps A..D are back in place.
    always_comb begin : step_chain
        logic [31:0] a, b, c, d, t, an;
        logic [5:0]  i;
        {a, b, c, d} = work;
        t  = '0;
        an = '0;
        i  = '0;
        for (int u = 0; u < UNROLL; u++) begin
            i  = cnt + 6'(u);
            t  = a + round_f(i[5:4], b, c, d) + blk[32*msg_idx(i) +: 32] + round_k(i[5:4]);
            an = rotl(t, shamt(i));
            {a, b, c, d} = {d, an, b, c};
        end
        work_next = {a, b, c, d};
    end

    assign cnt_next = cnt + 6'(UNROLL);

    always_comb begin
        result = work_next;
        if (ROUNDS == 3) begin
            for (int w = 0; w < 4; w++)
                result[32*w +: 32] = seed[32*w +: 32] + work_next[32*w +: 32];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            work       <= '0;
            seed       <= '0;
            blk        <= '0;
            digest_out <= '0;
            chain      <= IV;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    blk      <= block_in;
                    work     <= in_first ? IV : chain;
                    seed     <= in_first ? IV : chain;
                    cnt      <= '0;
                    state    <= RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    work <= work_next;
                    cnt  <= cnt_next;
                    if (cnt_next == 6'(TOTAL)) begin
                        digest_out <= result;
                        chain      <= result;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md4_compress_iter.sv
// Bench: five full-MD4 cores (UNROLL 1,2,4,8,16) plus one round-1-only core
// (UNROLL 2), checked against an RFC-style MD4 reference model.
module tb_md4_compress_iter;
    localparam int N = 6;
    localparam logic [127:0] IV      = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    localparam logic [127:0] D_EMPTY = 128'he0cfd631_31e96ad1_d7593cb7_c089c0e0;
    localparam logic [127:0] D_ABC   = 128'h7a0148a4_52d821af_e80ac15f_9d72a67a;

    logic         clk = 0, rst = 1;
    logic         in_first = 0;
    logic [511:0] block_in = '0;
    logic         iv   [N];
    logic         ir   [N];
    logic         ov   [N];
    logic         ordy [N];
    logic         bsy  [N];
    logic [127:0] dig  [N];

    int nvec = 0, nerr = 0;
    logic [127:0] chain_m [N];

    int kt [3][16] = '{'{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15},
                       '{0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15},
                       '{0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15}};
    int st [3][4]  = '{'{3,7,11,19}, '{3,5,9,13}, '{3,9,11,15}};
    logic [31:0] kc [3] = '{32'h0, 32'h5a827999, 32'h6ed9eba1};

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_dut
            md4_compress_iter #(.UNROLL(g == 5 ? 2 : (1 << g)), .ROUNDS(g == 5 ? 1 : 3)) u_dut (
                .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .in_first(in_first),
                .block_in(block_in), .out_valid(ov[g]), .out_ready(ordy[g]),
                .digest_out(dig[g]), .busy(bsy[g]));
        end
    endgenerate

    // RFC 1320 formulation: h[] = {A,B,C,D}; step j updates A,D,C,B in turn.
    function automatic logic [127:0] md4_model(input logic [127:0] sd, input logic [511:0] b, input int rounds);
        logic [31:0] h [4];
        logic [31:0] x [16];
        logic [31:0] p, q, r, f, v;
        int t, s;
        for (int j = 0; j < 16; j++) x[j] = b[32*j +: 32];
        for (int j = 0; j < 4; j++) h[j] = sd[127-32*j -: 32];
        for (int rr = 0; rr < rounds; rr++) begin
            for (int j = 0; j < 16; j++) begin
                t = (4 - j % 4) % 4;
                p = h[(t+1)%4]; q = h[(t+2)%4]; r = h[(t+3)%4];
                if (rr == 0)      f = (p & q) | (~p & r);
                else if (rr == 1) f = (p & q) | (p & r) | (q & r);
                else              f = p ^ q ^ r;
                s = st[rr][j%4];
                v = h[t] + f + x[kt[rr][j]] + kc[rr];
                h[t] = (v << s) | (v >> (32 - s));
            end
        end
        if (rounds == 3)
            for (int j = 0; j < 4; j++) h[j] = h[j] + sd[127-32*j -: 32];
        return {h[0], h[1], h[2], h[3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input int idx, input logic f, input logic [511:0] b,
                             input logic [127:0] exp, input string tag);
        int cyc, lat;
        lat = (idx == 5) ? 8 : 48 / (1 << idx);
        in_first = f; block_in = b; iv[idx] = 1;
        @(posedge clk); @(negedge clk);
        iv[idx] = 0;
        cyc = 0;
        do begin @(posedge clk); cyc++; @(negedge clk); end while (!ov[idx] && cyc < 200);
        chk({tag, "_lat"}, 128'(cyc), 128'(lat));
        chk(tag, dig[idx], exp);
        ordy[idx] = 1;
        @(posedge clk); @(negedge clk);
        ordy[idx] = 0;
        chk({tag, "_rdy"}, {126'b0, ir[idx], ov[idx]}, 128'b10);
        chain_m[idx] = exp;
    endtask

    initial begin : main
        logic [511:0] b_empty, b_abc, b_r1, b_rnd, b_alt;
        logic [127:0] e, sd;
        int idx;
        logic f;
        b_empty = '0; b_empty[31:0] = 32'h00000080;
        b_abc = '0; b_abc[31:0] = 32'h80636261; b_abc[32*14 +: 32] = 32'h00000018;
        b_r1 = '0; b_r1[31:0] = 32'h00000020; b_r1[32*14 +: 32] = 32'h80000000;
        b_r1[32*15 +: 32] = 32'h50535554;
        for (int i = 0; i < N; i++) begin iv[i] = 0; ordy[i] = 0; chain_m[i] = IV; end

        // Reset state
        #12;
        for (int i = 0; i < N; i++)
            chk($sformatf("reset%0d", i), {dig[i], ir[i], ov[i], bsy[i]} , {128'b0, 3'b100} >> 0);
        @(negedge clk); rst = 0;

        // Empty pad block, then chained with itself
        run_block(0, 1, b_empty, D_EMPTY, "empty");
        run_block(0, 0, b_empty, md4_model(D_EMPTY, b_empty, 3), "chain");

        // "abc" across every UNROLL
        for (int i = 0; i < 5; i++) run_block(i, 1, b_abc, D_ABC, $sformatf("abc_u%0d", 1 << i));

        // Round-1-only mode
        run_block(5, 1, b_r1, md4_model(IV, b_r1, 1), "r1");

        // Backpressure with an ignored in_valid
        in_first = 1; block_in = b_abc; iv[1] = 1;
        @(posedge clk); @(negedge clk);
        iv[1] = 0;
        for (int c = 0; c < 30 && !ov[1]; c++) begin @(posedge clk); @(negedge clk); end
        b_alt = b_empty; block_in = b_alt; in_first = 1; iv[1] = 1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("bp_hold%0d", c), {dig[1], ov[1], ir[1], bsy[1]}, {D_ABC, 3'b101});
            @(posedge clk); @(negedge clk);
        end
        iv[1] = 0; ordy[1] = 1;
        @(posedge clk); @(negedge clk);
        ordy[1] = 0;
        chk("bp_release", {dig[1], ir[1], ov[1], bsy[1]}, {D_ABC, 3'b100});
        chain_m[1] = D_ABC;

        // Randomized chained blocks
        for (int n = 0; n < 12; n++) begin
            idx = $urandom_range(0, N - 1);
            f = 1'($urandom_range(0, 1));
            for (int w = 0; w < 16; w++) b_rnd[32*w +: 32] = $urandom;
            sd = f ? IV : chain_m[idx];
            e = md4_model(sd, b_rnd, idx == 5 ? 1 : 3);
            run_block(idx, f, b_rnd, e, $sformatf("rnd%0d_i%0d", n, idx));
        end

        // Reset at step 20, then "abc" with in_first=0 must use the IV
        in_first = 1; block_in = b_empty; iv[0] = 1;
        @(posedge clk); @(negedge clk);
        iv[0] = 0;
        repeat (19) @(posedge clk);
        #2 rst = 1;
        #1 chk("rst_mid", {126'b0, ov[0], ir[0]}, 128'b01);
        chk("rst_busy", {127'b0, bsy[0]}, 128'b0);
        @(negedge clk); rst = 0;
        for (int i = 0; i < N; i++) chain_m[i] = IV;
        run_block(0, 0, b_abc, D_ABC, "abc_after_rst");
        run_block(5, 0, b_r1, md4_model(IV, b_r1, 1), "r1_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/md4_compress_iter.md
# md4_compress_iter

Iterative, parametrised MD4 compression engine. It replaces the fully combinational 16-step round-1 datapath with a clocked core that executes all 48 MD4 steps (rounds 1–3) over several cycles. UNROLL steps are evaluated per clock. The core holds the chaining value between blocks, applies the final feed-forward addition, and exchanges blocks and digests with neighbouring logic over valid/ready handshakes.

## Interface
- UNROLL, 1: steps evaluated per clock; legal values 1, 2, 4, 8, 16.
- ROUNDS, 3: rounds executed per block.
  - 3 is full MD4.
  - 1 is legacy round-1-only mode: 16 steps, no feed-forward.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  a block is offered on block_in.
- in_ready  output  1  core can accept a block; high only in IDLE.
- in_first  input  1  sampled with the block. 1 seeds from the IV; 0 seeds from the stored chaining value.
- block_in  input  512  message block; word j = block_in[32j+31:32j], used without byte swap.
- out_valid  output  1  digest_out is valid.
- out_ready  input  1  consumer accepts the digest.
- digest_out  output  128  {A,B,C,D}, with A in [127:96].
- busy  output  1  high in RUN or DONE.

## Operation
- IV: A=67452301, B=efcdab89, C=98badcfe, D=10325476.
- Step i: a' = rotl32(a + f(b,c,d) + X[k_i] + K_r, s_i), then (a,b,c,d) ← (d, a', b, c). All additions are mod 2^32.
- Round 1, steps 0–15:
  - f = (x&y)|(~x&z), K=0
  - s = 3,7,11,19 repeating
  - k = 0..15
- Round 2, steps 16–31:
  - f = (x&y)|(x&z)|(y&z), K=5a827999
  - s = 3,5,9,13
  - k = 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15
- Round 3, steps 32–47:
  - f = x^y^z, K=6ed9eba1
  - s = 3,9,11,15
  - k = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - latch block_in;
    - load the working registers from the IV (in_first=1) or from the chain registers (in_first=0);
    - step counter ← 0; → RUN.
  - RUN: each clock, apply UNROLL consecutive steps and add UNROLL to the step counter. On the clock that reaches TOTAL (48 or 16):
    - ROUNDS=3: digest_out ← seed + working, per 32-bit word; chain ← the same value.
    - ROUNDS=1: digest_out ← working registers; chain ← the same value.
    - Then → DONE.
  - DONE: out_valid=1 and digest_out held stable. On out_ready → IDLE.
- in_valid is ignored outside IDLE. Blocks never overlap.
- ROUNDS ∉ {1,3}, or UNROLL not dividing TOTAL, is a configuration error; an elaboration-time check fails the build.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, step counter=0;
  - working registers, digest_out and latched block = 0;
  - chain = IV;
  - out_valid=0, busy=0, in_ready=1.
- Reset asserted mid-RUN or in DONE discards the block. No digest is produced.
- Latency: accept edge E0. digest_out and out_valid update at edge E(TOTAL/UNROLL).
  - ROUNDS=3, UNROLL=1: 48 cycles.
  - UNROLL=16: 3 cycles.
- out_valid stays high until the edge at which out_ready=1. in_ready rises in the cycle after that edge.
- Throughput: one block per TOTAL/UNROLL + 2 cycles when out_ready is held high.
- in_first=0 on the first block after reset uses the IV, because chain resets to the IV.

## Test plan
- Empty-message pad block (word0=00000080, rest 0), in_first=1, ROUNDS=3, UNROLL=1 → digest_out = e0cfd631_31e96ad1_d7593cb7_c089c0e0, with out_valid exactly 48 cycles after acceptance.
- "abc" block (word0=80636261, word14=00000018), UNROLL ∈ {1,2,4,8,16} → digest 7a0148a4_52d821af_e80ac15f_9d72a67a every time, with latency 48/UNROLL.
- Chaining: empty pad block (in_first=1), then the same block with in_first=0 → second digest equals the software model seeded with e0cfd631, 31e96ad1, d7593cb7, c089c0e0.
- Backpressure: out_ready held low for 10 cycles → out_valid and digest_out stable, in_ready=0, a new in_valid ignored. Release → in_ready=1 in the next cycle.
- ROUNDS=1, seed = IV, block word15=50535554, word14=80000000, word0=00000020, other words 0 → digest_out equals the round-1-only software model (no feed-forward), 16/UNROLL cycles after acceptance.
- Reset asserted at step 20 → out_valid=0, in_ready=1 immediately. A subsequent "abc" block with in_first=0 still yields the "abc" digest, because chain was reset to the IV.
